// File: rtl/tt_um_priority_decoder_if.sv
// rtl/tt_um_priority_decoder_if.sv - pin bundle for the priority decoder tile
interface tt_um_priority_decoder_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_priority_decoder.sv
// rtl/tt_um_priority_decoder.sv - edge-triggered index-to-mask decoder with timed one-hot pulse
module tt_um_priority_decoder #(
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  localparam logic [7:0] PCNT_INIT = 8'(PULSE_LEN - 1);

  state_t      r_state;
  logic [15:0] r_mask;
  logic [15:0] r_out;
  logic [7:0]  r_last_ui;
  logic [7:0]  r_pcnt;
  logic [3:0]  r_parg;

  logic        w_exec;
  logic [3:0]  w_cmd;
  logic [3:0]  w_arg;
  logic [15:0] w_onehot;
  logic [15:0] w_mask_nxt;
  logic        w_start_pulse;
  logic        w_abort;
  logic        w_unused;

  assign w_unused = &{1'b0, ena, uio_in};

  // Commands fire only on a code change so a static bus executes once.
  assign w_exec   = (ui_in != r_last_ui);
  assign w_cmd    = ui_in[7:4];
  assign w_arg    = ui_in[3:0];
  assign w_onehot = 16'h0001 << w_arg;

  assign w_start_pulse = w_exec && (w_cmd == 4'h4);
  assign w_abort       = w_exec && (ui_in == 8'hF0);

  always_comb begin
    w_mask_nxt = r_mask;
    if (w_exec) begin
      case (w_cmd)
        4'h0: w_mask_nxt = w_onehot;
        4'h1: w_mask_nxt = r_mask | w_onehot;
        4'h2: w_mask_nxt = r_mask & ~w_onehot;
        4'h3: w_mask_nxt = r_mask ^ w_onehot;
        4'hF: if (w_arg == 4'h0) w_mask_nxt = 16'h0000;
        default: w_mask_nxt = r_mask;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mask    <= 16'h0000;
      r_out     <= 16'h0000;
      r_last_ui <= 8'hF0;
      r_pcnt    <= 8'h00;
      r_parg    <= 4'h0;
    end else begin
      r_last_ui <= ui_in;
      r_mask    <= w_mask_nxt;
      if (w_abort) begin
        r_state <= IDLE;
        r_pcnt  <= 8'h00;
        r_out   <= 16'h0000;
      end else if (w_start_pulse) begin
        r_state <= PULSE;
        r_parg  <= w_arg;
        r_pcnt  <= PCNT_INIT;
        r_out   <= w_onehot;
      end else begin
        case (r_state)
          IDLE: r_out <= w_mask_nxt;
          PULSE: begin
            // Mask edits during a pulse stay hidden until the count runs out.
            if (r_pcnt == 8'h00) begin
              r_state <= IDLE;
              r_out   <= w_mask_nxt;
            end else begin
              r_pcnt <= r_pcnt - 8'h01;
              r_out  <= 16'h0001 << r_parg;
            end
          end
          default: begin
            r_state <= IDLE;
            r_out   <= w_mask_nxt;
          end
        endcase
      end
    end
  end

  assign uo_out  = r_out[15:8];
  assign uio_out = r_out[7:0];
  assign uio_oe  = 8'hFF;

endmodule
